// File: rtl/success_arbiter.sv
// success_arbiter: watches a bank of parallel cracker cores, captures the
// first reported hit (arbitrating simultaneous hits by fixed priority or
// round-robin), and hands the result to the host through a start/ack
// handshake. An optional timeout ends a fruitless search.
module success_arbiter #(
    parameter int NUM_CRACKERS = 4,
    parameter int KEY_W        = 32,
    parameter int CYC_W        = 32,
    parameter int RR_MODE      = 0,
    localparam int IDX_W       = ($clog2(NUM_CRACKERS) > 1) ? $clog2(NUM_CRACKERS) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [CYC_W-1:0]              timeout_limit,
    input  logic                          ack,
    input  logic [NUM_CRACKERS-1:0]       found,
    input  logic [NUM_CRACKERS*KEY_W-1:0] found_key,
    output logic                          stop,
    output logic                          busy,
    output logic                          result_valid,
    output logic                          success,
    output logic                          timed_out,
    output logic [IDX_W-1:0]              winner,
    output logic [KEY_W-1:0]              key_out,
    output logic [IDX_W:0]                hit_count,
    output logic [CYC_W-1:0]              elapsed
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEARCH = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam int unsigned       NC        = NUM_CRACKERS;
    localparam logic [IDX_W-1:0]  PTR_RESET = IDX_W'(NUM_CRACKERS - 1);

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [CYC_W-1:0] timeout_q;
    logic [CYC_W-1:0] elapsed_inc;
    logic [CYC_W-1:0] elapsed_sat;
    logic             any_hit;
    logic             tmo_hit;
    logic             in_idle;
    logic             in_search;
    logic [IDX_W-1:0] fp_idx;
    logic             fp_hit;
    logic [IDX_W-1:0] rr_idx;
    logic             rr_hit;
    int unsigned      rr_pos;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W:0]   pop_count;
    logic [KEY_W-1:0] key_sel;

    // Fixed priority: the lowest-numbered asserted channel wins.
    always_comb begin
        fp_idx = '0;
        fp_hit = 1'b0;
        for (int unsigned i = 0; i < NC; i++) begin
            if (found[IDX_W'(i)] && !fp_hit) begin
                fp_idx = IDX_W'(i);
                fp_hit = 1'b1;
            end
        end
    end

    // Round-robin: scan upward from the channel after the last winner,
    // wrapping past the top index; the first asserted channel wins.
    always_comb begin
        rr_idx = '0;
        rr_hit = 1'b0;
        rr_pos = 0;
        for (int unsigned off = 0; off < NC; off++) begin
            // ptr+1+off never exceeds 2*NC-1, so one subtraction wraps it.
            rr_pos = 32'(rr_ptr) + 32'd1 + off;
            if (rr_pos >= NC) begin
                rr_pos = rr_pos - NC;
            end
            if (found[IDX_W'(rr_pos)] && !rr_hit) begin
                rr_idx = IDX_W'(rr_pos);
                rr_hit = 1'b1;
            end
        end
    end

    // Winner selection by arbitration mode, plus the number of hits seen.
    always_comb begin
        win_idx   = (RR_MODE != 0) ? rr_idx : fp_idx;
        pop_count = '0;
        for (int unsigned i = 0; i < NC; i++) begin
            pop_count = pop_count + (IDX_W+1)'(found[IDX_W'(i)]);
        end
    end

    // Key of the selected winner.
    always_comb begin
        key_sel = '0;
        for (int unsigned i = 0; i < NC; i++) begin
            if (win_idx == IDX_W'(i)) begin
                key_sel = found_key[i*KEY_W +: KEY_W];
            end
        end
    end

    // Search-cycle bookkeeping: saturating count and timeout detection.
    always_comb begin
        any_hit     = |found;
        in_idle     = (state == ST_IDLE);
        in_search   = (state == ST_SEARCH);
        elapsed_inc = elapsed + CYC_W'(1);
        elapsed_sat = (&elapsed) ? elapsed : elapsed_inc;
        tmo_hit     = (timeout_q != '0) && (elapsed_inc == timeout_q);
    end

    // Next-state logic; start is only honoured in IDLE and ack only in DONE.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (any_hit || tmo_hit) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                if (ack) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State register with registered handshake/status flags that track it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            stop         <= 1'b1;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_nx;
            stop         <= (state_nx != ST_SEARCH);
            busy         <= (state_nx == ST_SEARCH);
            result_valid <= (state_nx == ST_DONE);
        end
    end

    // Result registers: cleared on start, updated during SEARCH, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            success   <= 1'b0;
            timed_out <= 1'b0;
            winner    <= '0;
            key_out   <= '0;
            hit_count <= '0;
            elapsed   <= '0;
        end else if (in_idle && start) begin
            success   <= 1'b0;
            timed_out <= 1'b0;
            winner    <= '0;
            key_out   <= '0;
            hit_count <= '0;
            elapsed   <= '0;
        end else if (in_search) begin
            elapsed <= elapsed_sat;
            if (any_hit) begin
                // A hit on the same edge as the timeout takes precedence.
                success   <= 1'b1;
                timed_out <= 1'b0;
                winner    <= win_idx;
                key_out   <= key_sel;
                hit_count <= pop_count;
            end else if (tmo_hit) begin
                success   <= 1'b0;
                timed_out <= 1'b1;
            end
        end
    end

    // Timeout limit captured on the start edge; zero disables the timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_q <= '0;
        end else if (in_idle && start) begin
            timeout_q <= timeout_limit;
        end
    end

    // Last-winner pointer for round-robin; moves only on a captured hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= PTR_RESET;
        end else if (in_search && any_hit && (RR_MODE != 0)) begin
            rr_ptr <= rr_idx;
        end
    end

endmodule
